// File: rtl/cnn_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_job_sequencer
//  Purpose  : Queues convolution job descriptors, launches the CNN datapath
//             once per job with the job's configuration, then drains the
//             job's result words from the result buffer into a ready/valid
//             output stream. An inter-result watchdog abandons stuck jobs.
//  Ports    : clk, reset (async, active-high)
//             job_*            - job descriptor push interface (valid/ready)
//             cnn_*            - start pulse and held configuration to CNN
//             result_buffer_*  - single-outstanding read interface
//             out_*            - result stream (valid/ready, last per job)
//             busy, job_done, timeout_err - status
//  Revision : 1.0  initial release
// ============================================================================
module cnn_job_sequencer #(
    parameter int STRIDE_WIDTH        = 5,
    parameter int FILTER_SIZE_WIDTH   = 5,
    parameter int RESULT_BUFFER_WIDTH = 16,
    parameter int COUNT_WIDTH         = 8,
    parameter int JOB_QUEUE_DEPTH     = 4,
    parameter int TIMEOUT_WIDTH       = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           job_valid,
    output logic                           job_ready,
    input  logic [STRIDE_WIDTH-1:0]        job_stride,
    input  logic [FILTER_SIZE_WIDTH-1:0]   job_filter_size,
    input  logic                           job_psum_mode,
    input  logic [COUNT_WIDTH-1:0]         job_result_count,
    output logic                           cnn_start,
    output logic [STRIDE_WIDTH-1:0]        cnn_stride,
    output logic [FILTER_SIZE_WIDTH-1:0]   cnn_filter_size,
    output logic                           cnn_psum_mode,
    input  logic                           cnn_stall_signal,
    input  logic                           result_buffer_empty,
    input  logic                           result_buffer_valid,
    input  logic [RESULT_BUFFER_WIDTH-1:0] result_buffer_out,
    output logic                           result_buffer_read_enable,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [RESULT_BUFFER_WIDTH-1:0] out_data,
    output logic                           out_last,
    output logic                           busy,
    output logic                           job_done,
    output logic                           timeout_err
);

    localparam int PTR_WIDTH = $clog2(JOB_QUEUE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state, w_state_next;

    // ------------------------------------------------------------------
    // Job FIFO: pointers carry one extra wrap bit to tell full from empty
    // ------------------------------------------------------------------
    logic [STRIDE_WIDTH-1:0]      r_q_stride [JOB_QUEUE_DEPTH];
    logic [FILTER_SIZE_WIDTH-1:0] r_q_fsize  [JOB_QUEUE_DEPTH];
    logic                         r_q_psum   [JOB_QUEUE_DEPTH];
    logic [COUNT_WIDTH-1:0]       r_q_count  [JOB_QUEUE_DEPTH];
    logic [PTR_WIDTH:0]           r_wr_ptr, r_rd_ptr;
    logic                         w_q_full, w_q_empty, w_push, w_pop;

    assign w_q_empty = (r_wr_ptr == r_rd_ptr);
    assign w_q_full  = (r_wr_ptr[PTR_WIDTH] != r_rd_ptr[PTR_WIDTH]) &&
                       (r_wr_ptr[PTR_WIDTH-1:0] == r_rd_ptr[PTR_WIDTH-1:0]);
    // Gated by reset so every output reads 0 while reset is held.
    assign job_ready = !w_q_full && !reset;
    assign w_push    = job_valid && job_ready;
    assign w_pop     = (r_state == S_IDLE) && !w_q_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_stride[r_wr_ptr[PTR_WIDTH-1:0]] <= job_stride;
            r_q_fsize[r_wr_ptr[PTR_WIDTH-1:0]]  <= job_filter_size;
            r_q_psum[r_wr_ptr[PTR_WIDTH-1:0]]   <= job_psum_mode;
            r_q_count[r_wr_ptr[PTR_WIDTH-1:0]]  <= job_result_count;
        end
    end

    // ------------------------------------------------------------------
    // Job state, read handshake and watchdog
    // ------------------------------------------------------------------
    logic [COUNT_WIDTH-1:0]         r_count;
    logic [TIMEOUT_WIDTH-1:0]       r_wd;
    logic                           r_rd_hold;   // request issued, data not yet seen
    logic                           r_rd_cool;   // one idle cycle after each capture
    logic                           r_timed_out;
    logic                           r_out_valid, r_out_last;
    logic [RESULT_BUFFER_WIDTH-1:0] r_out_data;
    logic [STRIDE_WIDTH-1:0]        r_cfg_stride;
    logic [FILTER_SIZE_WIDTH-1:0]   r_cfg_fsize;
    logic                           r_cfg_psum;

    logic w_out_free, w_rd_en, w_capture, w_wd_expired, w_timeout, w_last_word;

    // The output register counts as free when it will be emptied this cycle.
    assign w_out_free   = !r_out_valid || out_ready;
    assign w_rd_en      = (r_state == S_RUN) && !r_rd_cool &&
                          (r_rd_hold || (!result_buffer_empty && w_out_free));
    assign w_capture    = w_rd_en && result_buffer_valid;
    assign w_wd_expired = (r_wd == {TIMEOUT_WIDTH{1'b1}});
    assign w_last_word  = (r_count == COUNT_WIDTH'(1));

    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        cnn_start    = 1'b0;
        job_done     = 1'b0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (!w_q_empty) w_state_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                cnn_start    = 1'b1;
                w_state_next = (r_count == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                // A captured word always wins over a watchdog expiry.
                if (w_capture) begin
                    if (w_last_word) w_state_next = S_DONE;
                end else if (w_wd_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                job_done     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_wd         <= '0;
            r_rd_hold    <= 1'b0;
            r_rd_cool    <= 1'b0;
            r_timed_out  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
            r_cfg_stride <= '0;
            r_cfg_fsize  <= '0;
            r_cfg_psum   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rd_cool   <= w_capture;
            r_timed_out <= w_timeout;
            r_rd_hold   <= w_rd_en && !result_buffer_valid && (w_state_next == S_RUN);

            if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_WIDTH+1)'(1);

            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + (PTR_WIDTH+1)'(1);
                r_cfg_stride <= r_q_stride[r_rd_ptr[PTR_WIDTH-1:0]];
                r_cfg_fsize  <= r_q_fsize[r_rd_ptr[PTR_WIDTH-1:0]];
                r_cfg_psum   <= r_q_psum[r_rd_ptr[PTR_WIDTH-1:0]];
                r_count      <= r_q_count[r_rd_ptr[PTR_WIDTH-1:0]];
            end else if (w_capture) begin
                r_count <= r_count - COUNT_WIDTH'(1);
            end

            // Watchdog only advances in RUN; freezes while the CNN stalls.
            if (r_state == S_LAUNCH) begin
                r_wd <= '0;
            end else if (r_state == S_RUN) begin
                if (w_capture)
                    r_wd <= '0;
                else if (!cnn_stall_signal && !w_wd_expired)
                    r_wd <= r_wd + TIMEOUT_WIDTH'(1);
            end

            // Output register runs independently of the FSM so a word pending
            // at timeout still completes its handshake.
            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_data  <= result_buffer_out;
                r_out_last  <= w_last_word;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign cnn_stride                = r_cfg_stride;
    assign cnn_filter_size           = r_cfg_fsize;
    assign cnn_psum_mode             = r_cfg_psum;
    assign result_buffer_read_enable = w_rd_en;
    assign out_valid                 = r_out_valid;
    assign out_data                  = r_out_data;
    assign out_last                  = r_out_last;
    assign timeout_err               = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_cnn_job_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_cnn_job_sequencer
//  Purpose  : Self-checking bench for cnn_job_sequencer. A behavioural result
//             buffer and a job/word scoreboard predict every output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cnn_job_sequencer;

    localparam int SW = 5, FW = 5, DW = 16, CW = 8, QD = 4, TW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          job_valid, job_ready, job_psum_mode;
    logic [SW-1:0] job_stride;
    logic [FW-1:0] job_filter_size;
    logic [CW-1:0] job_result_count;
    logic          cnn_start, cnn_psum_mode, cnn_stall_signal;
    logic [SW-1:0] cnn_stride;
    logic [FW-1:0] cnn_filter_size;
    logic          result_buffer_empty, result_buffer_valid, result_buffer_read_enable;
    logic [DW-1:0] result_buffer_out, out_data;
    logic          out_valid, out_ready, out_last, busy, job_done, timeout_err;

    always #5 clk = ~clk;

    cnn_job_sequencer #(
        .STRIDE_WIDTH(SW), .FILTER_SIZE_WIDTH(FW), .RESULT_BUFFER_WIDTH(DW),
        .COUNT_WIDTH(CW), .JOB_QUEUE_DEPTH(QD), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_stride(job_stride),
        .job_filter_size(job_filter_size), .job_psum_mode(job_psum_mode),
        .job_result_count(job_result_count),
        .cnn_start(cnn_start), .cnn_stride(cnn_stride), .cnn_filter_size(cnn_filter_size),
        .cnn_psum_mode(cnn_psum_mode), .cnn_stall_signal(cnn_stall_signal),
        .result_buffer_empty(result_buffer_empty), .result_buffer_valid(result_buffer_valid),
        .result_buffer_out(result_buffer_out),
        .result_buffer_read_enable(result_buffer_read_enable),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .job_done(job_done), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [SW-1:0] stride;
        logic [FW-1:0] fs;
        logic          psum;
        logic [CW-1:0] cnt;
        int            nwords;
    } job_t;
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } out_t;

    job_t          to_push[$], jobq[$], cur;
    logic [DW-1:0] pend[$], rbq[$], held_data;
    out_t          expq[$];

    int checks = 0, errors = 0;
    int pushed, popped, remaining, cyc, rb_lat, last_cap_cyc, wd_done_cyc;
    int n_start, n_done, n_out, n_last;
    bit push_en, ordy, stall, wd_mode, wd_seen, wd_flag;
    bit active, exp_done_now, exp_done_next, held_prev, prev_start, rb_req;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_job(input int stride, input int fs, input int psum, input int cnt,
                           input int nwords, input bit pattern);
        job_t j;
        logic [DW-1:0] w;
        j.stride = stride[SW-1:0];
        j.fs     = fs[FW-1:0];
        j.psum   = psum[0];
        j.cnt    = cnt[CW-1:0];
        j.nwords = nwords;
        to_push.push_back(j);
        for (int k = 0; k < nwords; k++) begin
            w = pattern ? DW'((k + 1) * 17) : DW'($urandom);
            pend.push_back(w);
        end
    endtask

    task automatic clear_model();
        to_push.delete(); jobq.delete(); pend.delete(); rbq.delete(); expq.delete();
        pushed = 0; popped = 0; remaining = 0; active = 0;
        exp_done_now = 0; exp_done_next = 0; held_prev = 0; prev_start = 0; rb_req = 0;
        cur.stride = '0; cur.fs = '0; cur.psum = 1'b0; cur.cnt = '0; cur.nwords = 0;
    endtask

    // One clock cycle: drive, emulate the result buffer, check, advance.
    task automatic cycle();
        job_t j;
        out_t e;
        logic [DW-1:0] w;
        job_valid = push_en && (to_push.size() > 0);
        if (to_push.size() > 0) begin
            j = to_push[0];
            job_stride = j.stride; job_filter_size = j.fs;
            job_psum_mode = j.psum; job_result_count = j.cnt;
        end
        out_ready           = ordy;
        cnn_stall_signal    = stall;
        result_buffer_empty = (rbq.size() == 0);
        result_buffer_valid = 1'b0;
        result_buffer_out   = DW'($urandom);
        #1;
        if (result_buffer_read_enable && rbq.size() > 0) begin
            if (!rb_req) begin rb_req = 1; rb_lat = $urandom_range(0, 2); end
            if (rb_lat == 0) begin
                result_buffer_valid = 1'b1;
                result_buffer_out   = rbq[0];
            end else begin
                rb_lat--;
            end
        end else begin
            rb_req = 0;
            // Stray valid without a request must be ignored by the DUT.
            if ($urandom_range(0, 5) == 0) result_buffer_valid = 1'b1;
        end
        #1;
        if (cnn_start) begin
            n_start++;
            popped++;
            check("start_single_pulse", 32'(prev_start), 32'd0);
            check("start_job_queued", 32'(jobq.size() != 0), 32'd1);
            if (jobq.size() != 0) begin
                cur = jobq.pop_front();
                remaining = int'(cur.cnt);
                active = 1;
                if (cur.cnt == 0) exp_done_next = 1;
            end
        end
        check("cfg_stride", 32'(cnn_stride), 32'(cur.stride));
        check("cfg_filter_size", 32'(cnn_filter_size), 32'(cur.fs));
        check("cfg_psum_mode", 32'(cnn_psum_mode), 32'(cur.psum));
        check("job_ready", 32'(job_ready), 32'((pushed - popped) < QD));
        check("busy", 32'(busy), 32'(active));
        if (!wd_mode) begin
            check("job_done", 32'(job_done), 32'(exp_done_now));
            check("timeout_err", 32'(timeout_err), 32'd0);
        end else if (job_done) begin
            wd_seen = 1; wd_done_cyc = cyc; wd_flag = timeout_err;
        end
        if (job_done) n_done++;
        if (out_valid && !out_ready) check("rd_blocked_when_full", 32'(result_buffer_read_enable), 32'd0);
        if (!active) check("rd_when_idle", 32'(result_buffer_read_enable), 32'd0);
        if (held_prev) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(held_data));
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (out_last) n_last++;
            check("out_word_expected", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check("out_data", 32'(out_data), 32'(e.d));
                check("out_last", 32'(out_last), 32'(e.l));
            end
        end
        if (result_buffer_read_enable && result_buffer_valid) begin
            check("read_needed", 32'(remaining > 0), 32'd1);
            if (rbq.size() > 0) void'(rbq.pop_front());
            rb_req = 0;
            last_cap_cyc = cyc;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) exp_done_next = 1;
            end
        end
        if (job_valid && job_ready) begin
            j = to_push.pop_front();
            pushed++;
            jobq.push_back(j);
            for (int k = 0; k < j.nwords; k++) begin
                w = pend.pop_front();
                rbq.push_back(w);
                e.d = w;
                e.l = (k == int'(j.cnt) - 1);
                expq.push_back(e);
            end
        end
        held_prev  = out_valid && !out_ready;
        held_data  = out_data;
        prev_start = cnn_start;
        if (wd_mode ? job_done : exp_done_now) active = 0;
        @(posedge clk);
        #1;
        exp_done_now  = exp_done_next;
        exp_done_next = 0;
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((to_push.size() != 0 || jobq.size() != 0 || active || expq.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    int s0, o0, l0, d0, p0, lat;

    initial begin
        clear_model();
        cyc = 0; n_start = 0; n_done = 0; n_out = 0; n_last = 0; rb_lat = 0;
        push_en = 1; ordy = 1; stall = 0; wd_mode = 0; wd_seen = 0; wd_flag = 0;
        last_cap_cyc = 0; wd_done_cyc = 0;
        reset = 1; job_valid = 0; job_stride = '0; job_filter_size = '0; job_psum_mode = 0;
        job_result_count = '0; cnn_stall_signal = 0; result_buffer_empty = 1;
        result_buffer_valid = 0; result_buffer_out = '0; out_ready = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_job_ready", 32'(job_ready), 32'd0);
        check("rst_cnn_start", 32'(cnn_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_read_enable", 32'(result_buffer_read_enable), 32'd0);
        check("rst_job_done", 32'(job_done), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_cfg", 32'({cnn_stride, cnn_filter_size, cnn_psum_mode}), 32'd0);
        reset = 0;
        #1;
        check("post_rst_job_ready", 32'(job_ready), 32'd1);

        // Single job, words 0x0011/0x0022/0x0033
        s0 = n_start; o0 = n_out; l0 = n_last;
        add_job(4, 4, 0, 3, 3, 1);
        drain("single_job_drained", 200);
        check("single_starts", 32'(n_start - s0), 32'd1);
        check("single_words", 32'(n_out - o0), 32'd3);
        check("single_lasts", 32'(n_last - l0), 32'd1);

        // Back-to-back jobs, psum 0 then 1
        s0 = n_start; o0 = n_out; l0 = n_last;
        add_job(2, 3, 0, 2, 2, 0);
        add_job(5, 1, 1, 2, 2, 0);
        drain("b2b_drained", 200);
        check("b2b_starts", 32'(n_start - s0), 32'd2);
        check("b2b_words", 32'(n_out - o0), 32'd4);
        check("b2b_lasts", 32'(n_last - l0), 32'd2);

        // Six jobs with the output blocked: five accepted, then full
        p0 = pushed; o0 = n_out;
        ordy = 0;
        for (int i = 0; i < 6; i++) add_job(i + 1, i + 2, i % 2, 2, 2, 0);
        repeat (20) cycle();
        check("full_accepted", 32'(pushed - p0), 32'd5);
        check("full_job_ready", 32'(job_ready), 32'd0);
        check("full_out_held", 32'(out_valid), 32'd1);
        check("full_no_words_out", 32'(n_out - o0), 32'd0);
        ordy = 1;
        drain("full_drained", 400);
        check("full_words", 32'(n_out - o0), 32'd12);

        // Zero-count job
        o0 = n_out; d0 = n_done;
        add_job(1, 1, 1, 0, 0, 0);
        drain("zero_drained", 50);
        check("zero_words", 32'(n_out - o0), 32'd0);
        check("zero_done", 32'(n_done - d0), 32'd1);

        // Watchdog: one of two words then silence
        wd_mode = 1; wd_seen = 0; wd_flag = 0;
        add_job(3, 3, 0, 2, 1, 0);
        for (int i = 0; i < 5000 && !wd_seen; i++) cycle();
        check("timeout_fired", 32'(wd_seen), 32'd1);
        check("timeout_with_done", 32'(wd_flag), 32'd1);
        lat = wd_done_cyc - last_cap_cyc;
        checks++;
        assert (lat >= 4095 && lat <= 4098) else begin
            errors++;
            $error("FAIL timeout_latency observed=%0d expected=4095..4098", lat);
        end
        repeat (3) cycle();

        // Watchdog frozen while stalled, fires once the stall lifts
        wd_seen = 0; stall = 1;
        add_job(3, 3, 1, 2, 1, 0);
        repeat (5000) cycle();
        check("stalled_no_timeout", 32'(wd_seen), 32'd0);
        check("stalled_still_busy", 32'(busy), 32'd1);
        stall = 0;
        for (int i = 0; i < 4300 && !wd_seen; i++) cycle();
        check("unstalled_timeout", 32'(wd_seen && wd_flag), 32'd1);
        repeat (3) cycle();
        wd_mode = 0;
        drain("wd_cleanup", 50);

        // Randomized jobs and handshakes
        d0 = n_done;
        for (int i = 0; i < 14; i++)
            add_job($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1),
                    $urandom_range(0, 5), 0, 0);
        // Word counts follow each job's count.
        for (int i = 0; i < 14; i++) begin
            to_push[i].nwords = int'(to_push[i].cnt);
            for (int k = 0; k < to_push[i].nwords; k++) pend.push_back(DW'($urandom));
        end
        for (int n = 0; n < 4000 && (to_push.size() != 0 || jobq.size() != 0 || active || expq.size() != 0); n++) begin
            push_en = ($urandom_range(0, 1) == 1);
            ordy    = ($urandom_range(0, 3) != 0);
            stall   = ($urandom_range(0, 4) == 0);
            cycle();
        end
        check("random_drained", 32'(to_push.size() == 0 && jobq.size() == 0 && !active && expq.size() == 0), 32'd1);
        check("random_done_count", 32'(n_done - d0), 32'd14);
        push_en = 1; ordy = 1; stall = 0;

        // Reset in the middle of a job
        ordy = 0;
        add_job(7, 2, 1, 3, 3, 0);
        add_job(6, 6, 0, 2, 2, 0);
        for (int i = 0; i < 50 && !out_valid; i++) cycle();
        check("pre_reset_out_valid", 32'(out_valid), 32'd1);
        reset = 1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_read_enable", 32'(result_buffer_read_enable), 32'd0);
        clear_model();
        job_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        ordy = 1;
        s0 = n_start;
        repeat (20) cycle();
        check("post_rst_no_launch", 32'(n_start - s0), 32'd0);
        check("post_rst_ready", 32'(job_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
